// File: rtl/teclado_matricial_if.sv
// Digit-buffer link between the keypad scanner and its consumers.
// The master side produces the buffer and strobe; teclado_en flows back from the consumer.
interface teclado_matricial_if;
  logic        teclado_en;
  logic [79:0] digitos_value;
  logic        digitos_valid;

  modport master (
    input  teclado_en,
    output digitos_value,
    output digitos_valid
  );

  modport slave (
    output teclado_en,
    input  digitos_value,
    input  digitos_valid
  );
endinterface

// File: rtl/teclado_matricial.sv
// 4x4 keypad scanner: synchronises, debounces and maps keys into a nibble shift buffer.
// Optional buffer inactivity timeout is enabled by defining TECLADO_TIMEOUT_EN.
module teclado_matricial #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int NUM_DIGITS      = 20
`ifdef TECLADO_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 250_000_000
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          row_i,
  output logic [3:0]          col_o,
  teclado_matricial_if.master bus
);

  localparam int VW  = 4 * NUM_DIGITS;
  localparam int SCW = $clog2(SCAN_DIV + 1);
  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_REPORT   = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t          state_q;
  logic [3:0]      row_meta_q;
  logic [3:0]      rs_q;
  logic [3:0]      col_q;
  logic [3:0]      row_lat_q;
  logic [SCW-1:0]  scan_cnt_q;
  logic [DCW-1:0]  deb_cnt_q;
  logic [VW-1:0]   digits_q;
  logic [VW-1:0]   digits_d;
  logic            valid_q;
  logic            clr_pend_q;
  logic [4:0]      key_entry;
  logic            timeout_hit;

  // Index of the single low bit in an active-low one-hot nibble.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    case (v)
      4'b1110: low_index = 2'd0;
      4'b1101: low_index = 2'd1;
      4'b1011: low_index = 2'd2;
      4'b0111: low_index = 2'd3;
      default: low_index = 2'd0;
    endcase
  endfunction

  function automatic logic one_low(input logic [3:0] v);
    case (v)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
      default:                            one_low = 1'b0;
    endcase
  endfunction

  // {reportable, code}; the letter column yields a non-reportable entry.
  function automatic logic [4:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'b00_00: key_lookup = {1'b1, 4'h1};
      4'b00_01: key_lookup = {1'b1, 4'h2};
      4'b00_10: key_lookup = {1'b1, 4'h3};
      4'b01_00: key_lookup = {1'b1, 4'h4};
      4'b01_01: key_lookup = {1'b1, 4'h5};
      4'b01_10: key_lookup = {1'b1, 4'h6};
      4'b10_00: key_lookup = {1'b1, 4'h7};
      4'b10_01: key_lookup = {1'b1, 4'h8};
      4'b10_10: key_lookup = {1'b1, 4'h9};
      4'b11_00: key_lookup = {1'b1, 4'hA};
      4'b11_01: key_lookup = {1'b1, 4'h0};
      4'b11_10: key_lookup = {1'b1, 4'hB};
      default:  key_lookup = {1'b0, 4'hF};
    endcase
  endfunction

  // Key decode from the latched row and frozen column, plus the shifted buffer.
  always_comb begin
    key_entry = key_lookup(low_index(row_lat_q), low_index(col_q));
    digits_d  = {digits_q[VW-5:0], key_entry[3:0]};
  end

  // Two-flop synchroniser for the asynchronous row lines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta_q <= 4'hF;
      rs_q       <= 4'hF;
    end else begin
      row_meta_q <= row_i;
      rs_q       <= row_meta_q;
    end
  end

  // Scan / debounce / report / release state machine.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_SCAN;
      col_q      <= 4'b1110;
      row_lat_q  <= 4'hF;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
    end else if (!bus.teclado_en) begin
      state_q    <= ST_SCAN;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_SCAN: begin
          if (rs_q != 4'hF) begin
            row_lat_q <= rs_q;
            deb_cnt_q <= DCW'(1);
            state_q   <= ST_DEBOUNCE;
          end else if (scan_cnt_q >= SCW'(SCAN_DIV - 1)) begin
            scan_cnt_q <= '0;
            col_q      <= {col_q[2:0], col_q[3]};
          end else begin
            scan_cnt_q <= scan_cnt_q + SCW'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (rs_q != row_lat_q) begin
            deb_cnt_q <= '0;
            state_q   <= ST_SCAN;
          end else if (deb_cnt_q >= DCW'(DEBOUNCE_CYCLES - 1)) begin
            deb_cnt_q <= '0;
            state_q   <= (one_low(row_lat_q) && key_entry[4]) ? ST_REPORT : ST_RELEASE;
          end else begin
            deb_cnt_q <= deb_cnt_q + DCW'(1);
          end
        end
        ST_REPORT: begin
          deb_cnt_q <= '0;
          state_q   <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (rs_q != 4'hF) begin
            deb_cnt_q <= '0;
          end else if (deb_cnt_q >= DCW'(DEBOUNCE_CYCLES - 1)) begin
            deb_cnt_q  <= '0;
            scan_cnt_q <= '0;
            state_q    <= ST_SCAN;
          end else begin
            deb_cnt_q <= deb_cnt_q + DCW'(1);
          end
        end
        default: begin
          deb_cnt_q  <= '0;
          scan_cnt_q <= '0;
          state_q    <= ST_SCAN;
        end
      endcase
    end
  end

  // Digit buffer and strobe; a terminator key empties the buffer one cycle after its strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digits_q   <= {VW{1'b1}};
      valid_q    <= 1'b0;
      clr_pend_q <= 1'b0;
    end else if (!bus.teclado_en) begin
      digits_q   <= {VW{1'b1}};
      valid_q    <= 1'b0;
      clr_pend_q <= 1'b0;
    end else if (state_q == ST_REPORT) begin
      digits_q   <= digits_d;
      valid_q    <= 1'b1;
      clr_pend_q <= (key_entry[3:0] == 4'hA) || (key_entry[3:0] == 4'hB);
    end else begin
      valid_q    <= 1'b0;
      clr_pend_q <= 1'b0;
      if (clr_pend_q || timeout_hit) begin
        digits_q <= {VW{1'b1}};
      end else begin
        digits_q <= digits_q;
      end
    end
  end

`ifdef TECLADO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q;
  logic          buf_busy;

  assign buf_busy    = (digits_q != {VW{1'b1}});
  assign timeout_hit = bus.teclado_en && buf_busy && (state_q != ST_REPORT)
                       && (to_cnt_q >= TW'(TIMEOUT_CYCLES - 1));

  // Inactivity counter: restarts on each report, when disabled, or when the buffer is empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_q <= '0;
    end else if (!bus.teclado_en || (state_q == ST_REPORT) || !buf_busy || timeout_hit) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + TW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign col_o             = col_q;
  assign bus.digitos_value = digits_q;
  assign bus.digitos_valid = valid_q;

endmodule
